// File: rtl/alu_ctrl_unit.sv
// Hack-format instruction sequencer driving an external combinational ALU.
// Owns A/D registers, decodes C-instructions, writes back to A, D and memory.
module alu_ctrl_unit #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [15:0]          i_instr,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_zx,
  output logic                 o_nx,
  output logic                 o_zy,
  output logic                 o_ny,
  output logic                 o_f,
  output logic                 o_no,
  output logic [BUS_WIDTH-1:0] o_X,
  output logic [BUS_WIDTH-1:0] o_Y,
  input  logic [BUS_WIDTH-1:0] i_O,
  input  logic [BUS_WIDTH-1:0] i_M,
  output logic [BUS_WIDTH-1:0] o_m_addr,
  output logic [BUS_WIDTH-1:0] o_m_wdata,
  output logic                 o_m_we,
  output logic [BUS_WIDTH-1:0] o_A,
  output logic [BUS_WIDTH-1:0] o_D,
  output logic                 o_done,
  output logic                 o_jump,
  output logic                 o_zr,
  output logic                 o_ng,
  output logic [1:0]           o_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic                 is_c_q;
  logic                 a_sel_q;
  logic [5:0]           ctrl_q;
  logic [2:0]           dest_q;
  logic [2:0]           jmp_q;
  logic [BUS_WIDTH-1:0] a_q;
  logic [BUS_WIDTH-1:0] d_q;
  logic [BUS_WIDTH-1:0] res_q;
  logic [BUS_WIDTH-1:0] waddr_q;
  logic                 zr_q;
  logic                 ng_q;
  logic                 accept;
  logic                 in_exec;
  logic                 c_done;

  // Handshake: an instruction transfers on a rising edge where i_valid and
  // o_ready are both high; the source holds i_instr/i_valid until then.
  assign o_ready = (state == IDLE) && !i_rst;
  assign accept  = i_valid && o_ready;
  assign in_exec = (state == EXEC);
  assign c_done  = (state == DONE) && is_c_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      is_c_q  <= 1'b0;
      a_sel_q <= 1'b0;
      ctrl_q  <= '0;
      dest_q  <= '0;
      jmp_q   <= '0;
      a_q     <= '0;
      d_q     <= '0;
      res_q   <= '0;
      waddr_q <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_c_q  <= i_instr[15];
            a_sel_q <= i_instr[12];
            ctrl_q  <= i_instr[11:6];
            dest_q  <= i_instr[5:3];
            jmp_q   <= i_instr[2:0];
            if (i_instr[15]) begin
              state <= EXEC;
            end else begin
              a_q   <= {{(BUS_WIDTH-15){1'b0}}, i_instr[14:0]};
              state <= DONE;
            end
          end
        end
        EXEC: begin
          res_q   <= i_O;
          zr_q    <= (i_O == '0);
          ng_q    <= i_O[BUS_WIDTH-1];
          // Memory write targets the A value seen by the ALU, not the updated one.
          waddr_q <= a_q;
          if (dest_q[2]) a_q <= i_O;
          if (dest_q[1]) d_q <= i_O;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign {o_zx, o_nx, o_zy, o_ny, o_f, o_no} = in_exec ? ctrl_q : 6'b0;

  assign o_X       = d_q;
  assign o_Y       = (in_exec && a_sel_q) ? i_M : a_q;
  assign o_m_we    = c_done && dest_q[0];
  assign o_m_addr  = o_m_we ? waddr_q : a_q;
  assign o_m_wdata = res_q;
  assign o_A       = a_q;
  assign o_D       = d_q;
  assign o_done    = (state == DONE);
  assign o_jump    = c_done && ((jmp_q[2] && ng_q) || (jmp_q[1] && zr_q) ||
                                (jmp_q[0] && !ng_q && !zr_q));
  assign o_zr      = zr_q;
  assign o_ng      = ng_q;
  assign o_state   = state;

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed bench for alu_ctrl_unit with a behavioural Hack ALU on the operand path.
module tb_alu_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        valid;
  logic        ready;
  logic        zx, nx, zy, ny, f, no;
  logic [15:0] x_op, y_op, alu_o, mem_rd;
  logic [15:0] m_addr, m_wdata, a_reg, d_reg;
  logic        m_we, done, jump, zr, ng;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_ctrl_unit #(.BUS_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_valid(valid), .o_ready(ready),
    .o_zx(zx), .o_nx(nx), .o_zy(zy), .o_ny(ny), .o_f(f), .o_no(no),
    .o_X(x_op), .o_Y(y_op), .i_O(alu_o), .i_M(mem_rd),
    .o_m_addr(m_addr), .o_m_wdata(m_wdata), .o_m_we(m_we),
    .o_A(a_reg), .o_D(d_reg), .o_done(done), .o_jump(jump),
    .o_zr(zr), .o_ng(ng), .o_state(state)
  );

  // Reference Hack ALU
  always_comb begin
    logic [15:0] xv, yv, ov;
    xv = zx ? 16'h0 : x_op;
    xv = nx ? ~xv : xv;
    yv = zy ? 16'h0 : y_op;
    yv = ny ? ~yv : yv;
    ov = f ? (xv + yv) : (xv & yv);
    alu_o = no ? ~ov : ov;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_a(input string tag, input logic [15:0] ins, input logic [15:0] exp_a,
                      input logic exp_zr, input logic exp_ng);
    check({tag, ".ready"}, ready, 1);
    valid = 1'b1;
    instr = ins;
    @(negedge clk);
    valid = 1'b0;
    #1;
    check({tag, ".done"}, done, 1);
    check({tag, ".A"}, a_reg, exp_a);
    check({tag, ".addr"}, m_addr, exp_a);
    check({tag, ".jump"}, jump, 0);
    check({tag, ".we"}, m_we, 0);
    check({tag, ".flags"}, {zr, ng}, {exp_zr, exp_ng});
    check({tag, ".busy"}, ready, 0);
    @(negedge clk);
    #1;
    check({tag, ".idle_done"}, done, 0);
    check({tag, ".idle_ready"}, ready, 1);
  endtask

  task automatic do_c(input string tag, input logic [15:0] ins, input logic [5:0] exp_ctrl,
                      input logic [15:0] exp_y, input logic [15:0] exp_a,
                      input logic [15:0] exp_d, input logic exp_we,
                      input logic [15:0] exp_addr, input logic [15:0] exp_res,
                      input logic exp_jump, input logic exp_zr, input logic exp_ng);
    check({tag, ".ready"}, ready, 1);
    valid = 1'b1;
    instr = ins;
    @(negedge clk);
    valid = 1'b0;
    #1;
    check({tag, ".exec_state"}, state, 1);
    check({tag, ".ctrl"}, {zx, nx, zy, ny, f, no}, exp_ctrl);
    check({tag, ".Y"}, y_op, exp_y);
    check({tag, ".exec_quiet"}, {done, m_we, jump, ready}, 0);
    @(negedge clk);
    #1;
    check({tag, ".done"}, done, 1);
    check({tag, ".ctrl_off"}, {zx, nx, zy, ny, f, no}, 0);
    check({tag, ".A"}, a_reg, exp_a);
    check({tag, ".D"}, d_reg, exp_d);
    check({tag, ".we"}, m_we, exp_we);
    check({tag, ".addr"}, m_addr, exp_addr);
    check({tag, ".wdata"}, m_wdata, exp_res);
    check({tag, ".jump"}, jump, exp_jump);
    check({tag, ".flags"}, {zr, ng}, {exp_zr, exp_ng});
    @(negedge clk);
    #1;
    check({tag, ".after"}, {done, m_we, jump, ready}, 4'b0001);
    check({tag, ".after_addr"}, m_addr, exp_a);
  endtask

  initial begin
    rst    = 1'b1;
    valid  = 1'b0;
    instr  = 16'h0;
    mem_rd = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.ready", ready, 0);
    check("rst.AD", {a_reg, d_reg}, 0);
    check("rst.outs", {done, m_we, jump, zr, ng}, 0);
    check("rst.ctrl", {zx, nx, zy, ny, f, no}, 0);
    check("rst.wdata", m_wdata, 0);
    check("rst.state", state, 0);
    rst = 1'b0;
    #1;
    check("rst.release_ready", ready, 1);

    do_a("at5", 16'h0005, 16'h0005, 1'b0, 1'b0);
    do_c("d_eq_a", 16'hEC10, 6'b110000, 16'h0005, 16'h0005, 16'h0005, 1'b0, 16'h0005,
         16'h0005, 1'b0, 1'b0, 1'b0);
    do_a("at3", 16'h0003, 16'h0003, 1'b0, 1'b0);
    do_c("d_plus_a", 16'hE090, 6'b000010, 16'h0003, 16'h0003, 16'h0008, 1'b0, 16'h0003,
         16'h0008, 1'b0, 1'b0, 1'b0);
    do_c("m_eq_d", 16'hE308, 6'b001100, 16'h0003, 16'h0003, 16'h0008, 1'b1, 16'h0003,
         16'h0008, 1'b0, 1'b0, 1'b0);
    do_c("zero_jmp", 16'hEA87, 6'b101010, 16'h0003, 16'h0003, 16'h0008, 1'b0, 16'h0003,
         16'h0000, 1'b1, 1'b1, 1'b0);
    do_c("d_jgt", 16'hE301, 6'b001100, 16'h0003, 16'h0003, 16'h0008, 1'b0, 16'h0003,
         16'h0008, 1'b1, 1'b0, 1'b0);
    do_c("d_m1", 16'hEE90, 6'b111010, 16'h0003, 16'h0003, 16'hFFFF, 1'b0, 16'h0003,
         16'hFFFF, 1'b0, 1'b0, 1'b1);
    do_c("neg_jgt", 16'hE301, 6'b001100, 16'h0003, 16'h0003, 16'hFFFF, 1'b0, 16'h0003,
         16'hFFFF, 1'b0, 1'b0, 1'b1);

    // A-instruction keeps the negative flag from the previous C-instruction
    do_a("at7", 16'h0007, 16'h0007, 1'b0, 1'b1);
    mem_rd = 16'h0010;
    do_c("am_m1", 16'hFDE8, 6'b110111, 16'h0010, 16'h0011, 16'hFFFF, 1'b1, 16'h0007,
         16'h0011, 1'b0, 1'b0, 1'b0);

    do_a("at2", 16'h0002, 16'h0002, 1'b0, 1'b0);
    mem_rd = 16'h1234;
    do_c("d_eq_m", 16'hFC10, 6'b110000, 16'h1234, 16'h0002, 16'h1234, 1'b0, 16'h0002,
         16'h1234, 1'b0, 1'b0, 1'b0);

    // Reset lands during EXEC; a held A-instruction must not be taken meanwhile
    check("mid.ready", ready, 1);
    valid = 1'b1;
    instr = 16'hE090;
    @(negedge clk);
    #1;
    check("mid.exec", state, 1);
    rst   = 1'b1;
    instr = 16'h0009;
    @(negedge clk);
    #1;
    check("mid.AD", {a_reg, d_reg}, 0);
    check("mid.quiet", {done, m_we, jump}, 0);
    check("mid.ready_held", ready, 0);
    check("mid.state", state, 0);
    @(negedge clk);
    #1;
    check("mid.ready_held2", ready, 0);
    check("mid.no_accept", a_reg, 0);
    rst   = 1'b0;
    valid = 1'b0;
    #1;
    check("mid.release_ready", ready, 1);
    @(negedge clk);
    #1;
    check("mid.final", {done, m_we, a_reg, d_reg}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
